idex_operand_stage: RTL and testbench

- ID/EX pipeline stage that sits directly upstream of the ALU.
- Registers decoded instruction fields from the decode stage and supports stall and flush.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Drives the ALU operand and opcode inputs (A, B, op), plus the destination, write-enable and store-data fields carried to the EX/MEM register.

---
 rtl/idex_operand_stage.sv | 134 +++++++++++++
 tb/tb_idex_operand_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/idex_operand_stage.sv
// ID/EX stage register feeding the ALU: captures decoded fields with stall/flush,
// then resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
module idex_operand_stage #(
  parameter int WORD_LEN = 32,
  parameter int REG_IDX  = 5,
  parameter int IMM_LEN  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [3:0]          in_op,
  input  logic [WORD_LEN-1:0] in_rs_val,
  input  logic [WORD_LEN-1:0] in_rt_val,
  input  logic [IMM_LEN-1:0]  in_imm,
  input  logic                in_alusrc,
  input  logic [REG_IDX-1:0]  in_rs_idx,
  input  logic [REG_IDX-1:0]  in_rt_idx,
  input  logic [REG_IDX-1:0]  in_rd_idx,
  input  logic                in_regwrite,
  input  logic                exmem_regwrite,
  input  logic [REG_IDX-1:0]  exmem_rd,
  input  logic [WORD_LEN-1:0] exmem_result,
  input  logic                memwb_regwrite,
  input  logic [REG_IDX-1:0]  memwb_rd,
  input  logic [WORD_LEN-1:0] memwb_result,
  output logic                ex_valid,
  output logic [WORD_LEN-1:0] alu_a,
  output logic [WORD_LEN-1:0] alu_b,
  output logic [3:0]          alu_op,
  output logic [REG_IDX-1:0]  ex_rd,
  output logic                ex_regwrite,
  output logic [WORD_LEN-1:0] ex_store_data,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b
);

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  logic                valid_q;
  logic [3:0]          op_q;
  logic [WORD_LEN-1:0] rs_val_q;
  logic [WORD_LEN-1:0] rt_val_q;
  logic [IMM_LEN-1:0]  imm_q;
  logic                alusrc_q;
  logic [REG_IDX-1:0]  rs_idx_q;
  logic [REG_IDX-1:0]  rt_idx_q;
  logic [REG_IDX-1:0]  rd_idx_q;
  logic                regwrite_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      op_q       <= '0;
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      rs_idx_q   <= '0;
      rt_idx_q   <= '0;
      rd_idx_q   <= '0;
      regwrite_q <= 1'b0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      op_q       <= '0;
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      rs_idx_q   <= '0;
      rt_idx_q   <= '0;
      rd_idx_q   <= '0;
      regwrite_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= in_valid;
      op_q       <= in_op;
      rs_val_q   <= in_rs_val;
      rt_val_q   <= in_rt_val;
      imm_q      <= in_imm;
      alusrc_q   <= in_alusrc;
      rs_idx_q   <= in_rs_idx;
      rt_idx_q   <= in_rt_idx;
      rd_idx_q   <= in_rd_idx;
      regwrite_q <= in_regwrite & in_valid;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is never forwarded.
  logic [WORD_LEN-1:0] rs_fwd;
  logic [WORD_LEN-1:0] rt_fwd;
  logic [WORD_LEN-1:0] imm_ext;

  always_comb begin
    fwd_a  = FWD_NONE;
    rs_fwd = rs_val_q;
    if (exmem_regwrite && exmem_rd != '0 && exmem_rd == rs_idx_q) begin
      fwd_a  = FWD_EXMEM;
      rs_fwd = exmem_result;
    end else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == rs_idx_q) begin
      fwd_a  = FWD_MEMWB;
      rs_fwd = memwb_result;
    end

    fwd_b  = FWD_NONE;
    rt_fwd = rt_val_q;
    if (exmem_regwrite && exmem_rd != '0 && exmem_rd == rt_idx_q) begin
      fwd_b  = FWD_EXMEM;
      rt_fwd = exmem_result;
    end else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == rt_idx_q) begin
      fwd_b  = FWD_MEMWB;
      rt_fwd = memwb_result;
    end
  end

  // Logical ops (OR, AND) take a zero-extended immediate; everything else is signed.
  always_comb begin
    if (op_q == 4'b0001 || op_q == 4'b0000)
      imm_ext = WORD_LEN'(imm_q);
    else
      imm_ext = WORD_LEN'($signed(imm_q));
  end

  assign alu_a         = rs_fwd;
  assign alu_b         = alusrc_q ? imm_ext : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_op        = op_q;
  assign ex_rd         = rd_idx_q;
  assign ex_valid      = valid_q;
  assign ex_regwrite   = regwrite_q;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed bench for idex_operand_stage: capture, forwarding priority,
// immediate extension, stall/flush and reset behaviour.
module tb_idex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, in_valid, in_alusrc, in_regwrite;
  logic [3:0]  in_op;
  logic [31:0] in_rs_val, in_rt_val;
  logic [15:0] in_imm;
  logic [4:0]  in_rs_idx, in_rt_idx, in_rd_idx;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_regwrite;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  ex_rd;
  logic [1:0]  fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  idex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_imm(in_imm), .in_alusrc(in_alusrc), .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx),
    .in_rd_idx(in_rd_idx), .in_regwrite(in_regwrite),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_store_data(ex_store_data), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; in_valid = 0; in_alusrc = 0; in_regwrite = 0;
    in_op = 4'b0000; in_rs_val = '0; in_rt_val = '0; in_imm = '0;
    in_rs_idx = '0; in_rt_idx = '0; in_rd_idx = '0;
    exmem_regwrite = 0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic load(input logic [3:0] op, input logic [31:0] rs_v, input logic [31:0] rt_v,
                      input logic [15:0] imm, input logic alusrc, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic rw);
    in_valid = 1; in_op = op; in_rs_val = rs_v; in_rt_val = rt_v; in_imm = imm;
    in_alusrc = alusrc; in_rs_idx = rs; in_rt_idx = rt; in_rd_idx = rd; in_regwrite = rw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    chk("rst_valid", ex_valid, 0);
    chk("rst_regwrite", ex_regwrite, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;

    // plain capture, no hazards
    load(4'b0010, 32'd5, 32'd7, 16'h0, 0, 5'd1, 5'd2, 5'd3, 1);
    step();
    chk("cap_alu_a", alu_a, 5);
    chk("cap_alu_b", alu_b, 7);
    chk("cap_op", alu_op, 4'b0010);
    chk("cap_rd", ex_rd, 3);
    chk("cap_regwrite", ex_regwrite, 1);
    chk("cap_valid", ex_valid, 1);
    chk("cap_fwd_a", fwd_a, 0);
    chk("cap_fwd_b", fwd_b, 0);

    // asynchronous reset in the middle of a cycle
    #3 rst_n = 0;
    #1;
    chk("mid_rst_valid", ex_valid, 0);
    chk("mid_rst_regwrite", ex_regwrite, 0);
    chk("mid_rst_op", alu_op, 0);
    chk("mid_rst_rd", ex_rd, 0);
    #1 rst_n = 1;

    // both producers match rs and rt
    load(4'b0010, 32'h100, 32'h200, 16'h0, 0, 5'd4, 5'd4, 5'd8, 1);
    step();
    exmem_regwrite = 1; exmem_rd = 5'd4; exmem_result = 32'h11;
    memwb_regwrite = 1; memwb_rd = 5'd4; memwb_result = 32'h22;
    #1;
    chk("dbl_alu_a", alu_a, 32'h11);
    chk("dbl_alu_b", alu_b, 32'h11);
    chk("dbl_fwd_a", fwd_a, 2'b10);
    chk("dbl_fwd_b", fwd_b, 2'b10);
    exmem_regwrite = 0;
    #1;
    chk("wb_alu_a", alu_a, 32'h22);
    chk("wb_alu_b", alu_b, 32'h22);
    chk("wb_fwd_a", fwd_a, 2'b01);
    chk("wb_fwd_b", fwd_b, 2'b01);
    exmem_regwrite = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1;
    chk("r0_alu_a", alu_a, 32'h100);
    chk("r0_alu_b", alu_b, 32'h200);
    chk("r0_fwd_a", fwd_a, 0);
    chk("r0_fwd_b", fwd_b, 0);
    exmem_regwrite = 0; memwb_regwrite = 0;

    // immediate extension
    load(4'b0010, 32'h1, 32'h2, 16'hFFFF, 1, 5'd5, 5'd6, 5'd7, 1);
    step();
    chk("sext_alu_b", alu_b, 32'hFFFF_FFFF);
    load(4'b0001, 32'h1, 32'h2, 16'hFFFF, 1, 5'd5, 5'd6, 5'd7, 1);
    step();
    chk("zext_alu_b", alu_b, 32'h0000_FFFF);
    exmem_regwrite = 1; exmem_rd = 5'd6; exmem_result = 32'hABCD;
    #1;
    chk("st_data_fwd", ex_store_data, 32'hABCD);
    chk("st_fwd_b", fwd_b, 2'b10);
    chk("st_alu_b_imm", alu_b, 32'h0000_FFFF);
    exmem_regwrite = 0;
    load(4'b0111, 32'h1, 32'h2, 16'h7FFF, 1, 5'd5, 5'd6, 5'd7, 1);
    step();
    chk("sext_pos_alu_b", alu_b, 32'h0000_7FFF);
    load(4'b0000, 32'h1, 32'h2, 16'h8000, 1, 5'd5, 5'd6, 5'd7, 1);
    step();
    chk("and_zext_alu_b", alu_b, 32'h0000_8000);

    // stall holds X while inputs change
    load(4'b0110, 32'h33, 32'h44, 16'h0, 0, 5'd10, 5'd11, 5'd9, 1);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      load(4'b1100, 32'h55 + i, 32'h66, 16'h1234, 1, 5'd12, 5'd13, 5'd14, 0);
      step();
      chk("stall_alu_a", alu_a, 32'h33);
      chk("stall_alu_b", alu_b, 32'h44);
      chk("stall_op", alu_op, 4'b0110);
      chk("stall_rd", ex_rd, 9);
      chk("stall_regwrite", ex_regwrite, 1);
    end
    flush = 1;
    step();
    chk("flush_valid", ex_valid, 0);
    chk("flush_regwrite", ex_regwrite, 0);
    chk("flush_op", alu_op, 0);
    chk("flush_alu_a", alu_a, 0);
    chk("flush_rd", ex_rd, 0);
    stall = 0; flush = 0;

    // invalid input suppresses regwrite
    load(4'b0010, 32'h9, 32'h9, 16'h0, 0, 5'd1, 5'd2, 5'd3, 1);
    in_valid = 0;
    step();
    chk("inv_valid", ex_valid, 0);
    chk("inv_regwrite", ex_regwrite, 0);
    chk("inv_alu_a", alu_a, 32'h9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
